// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the MIPS-DLX core.
//
// Captures operands, extended immediate, register indices and control from the
// decode stage on every rising clock edge. Detects load-use hazards against the
// instruction currently in EX, holds IF/ID for LOAD_STALL cycles and inserts
// bubbles into EX meanwhile. A taken-branch flush squashes the EX slot.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   - operand capture forwards wb_busw when the write-back target
//               matches ra/rb (independent of register-bank write timing).
//   undefined - id_bus_a/id_bus_b captured as-is; wb_* ports are ignored.
//
// Ports:
//   clock, reset            clock; synchronous active-high reset
//   id_*                    decoded instruction fields from the ID slot
//   flush                   squash the instruction entering EX
//   wb_reg_write/rw/busw    write-back port (used only with WB_BYPASS_EN)
//   stall_if_id             combinational hold request for PC and IF/ID
//   ex_*                    registered EX slot contents
module id_ex_stage #(
  parameter int unsigned CTRL_W     = 8,
  parameter int unsigned LOAD_STALL = 1   // legal 1..3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_ra,
  input  logic [4:0]        id_rb,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rb,
  input  logic [31:0]       id_bus_a,
  input  logic [31:0]       id_bus_b,
  input  logic [15:0]       id_imm,
  input  logic              id_imm_zext,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_rw,
  input  logic [31:0]       wb_busw,
  output logic              stall_if_id,
  output logic              ex_valid,
  output logic [31:0]       ex_bus_a,
  output logic [31:0]       ex_bus_b,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_ra,
  output logic [4:0]        ex_rb,
  output logic [4:0]        ex_rd,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic [CTRL_W-1:0] ex_ctrl
);

  typedef enum logic {StRun, StStall} state_e;

  typedef struct packed {
    logic              valid;
    logic [31:0]       bus_a;
    logic [31:0]       bus_b;
    logic [31:0]       imm;
    logic [4:0]        ra;
    logic [4:0]        rb;
    logic [4:0]        rd;
    logic              mem_read;
    logic              reg_write;
    logic [CTRL_W-1:0] ctrl;
  } ex_t;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  ex_t        ex_q, ex_d;
  ex_t        cap;
  logic       hazard;
  logic       stall_d;
  logic [31:0] cap_bus_a, cap_bus_b;

`ifdef WB_BYPASS_EN
  // Forward the value being written back this cycle so capture does not depend
  // on which clock edge the register bank writes on.
  always_comb begin
    cap_bus_a = id_bus_a;
    cap_bus_b = id_bus_b;
    if (wb_reg_write && (wb_rw != 5'd0) && (wb_rw == id_ra)) cap_bus_a = wb_busw;
    if (wb_reg_write && (wb_rw != 5'd0) && (wb_rw == id_rb)) cap_bus_b = wb_busw;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_reg_write, wb_rw, wb_busw};
  assign cap_bus_a = id_bus_a;
  assign cap_bus_b = id_bus_b;
`endif

  always_comb begin
    cap.valid     = 1'b1;
    cap.bus_a     = cap_bus_a;
    cap.bus_b     = cap_bus_b;
    cap.imm       = {{16{id_imm[15] & ~id_imm_zext}}, id_imm};
    cap.ra        = id_ra;
    cap.rb        = id_rb;
    cap.rd        = id_rd;
    cap.mem_read  = id_mem_read;
    cap.reg_write = id_reg_write;
    cap.ctrl      = id_ctrl;
  end

  // r0 is never a hazard source.
  assign hazard = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                  ((ex_q.rd == id_ra) | (id_uses_rb & (ex_q.rd == id_rb)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ex_d    = '0;   // bubble unless an instruction is captured
    stall_d = 1'b0;
    unique case (state_q)
      StRun: begin
        if (flush) begin
          state_d = StRun;
        end else if (hazard) begin
          stall_d = 1'b1;
          cnt_d   = 2'(LOAD_STALL - 1);
          state_d = (LOAD_STALL > 1) ? StStall : StRun;
        end else if (id_valid) begin
          ex_d = cap;
        end
      end
      StStall: begin
        if (flush) begin
          state_d = StRun;
          cnt_d   = 2'd0;
        end else begin
          stall_d = 1'b1;
          cnt_d   = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = StRun;
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Reset overrides any hazard seen on the ID inputs.
  assign stall_if_id = stall_d & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= 2'd0;
      ex_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_bus_a     = ex_q.bus_a;
  assign ex_bus_b     = ex_q.bus_b;
  assign ex_imm       = ex_q.imm;
  assign ex_ra        = ex_q.ra;
  assign ex_rb        = ex_q.rb;
  assign ex_rd        = ex_q.rd;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_ctrl      = ex_q.ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage. Two instances share the
// same stimulus, one with LOAD_STALL=1 and one with LOAD_STALL=3. A reference
// model tracks the EX slot contents and the number of stall cycles still owed.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] bus_a;
    logic [31:0] bus_b;
    logic [31:0] imm;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rd;
    logic        mem_read;
    logic        reg_write;
    logic [7:0]  ctrl;
  } ex_t;

  typedef struct packed {
    logic        reset;
    logic        flush;
    logic        id_valid;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rd;
    logic        uses_rb;
    logic [31:0] bus_a;
    logic [31:0] bus_b;
    logic [15:0] imm;
    logic        zext;
    logic        mem_read;
    logic        reg_write;
    logic [7:0]  ctrl;
    logic        wb_we;
    logic [4:0]  wb_rw;
    logic [31:0] wb_busw;
  } stim_t;

  typedef struct packed {
    logic stall0;
    logic stall1;
    ex_t  e0;
    ex_t  e1;
  } exp_t;

  logic  clock = 1'b0;
  stim_t cur = '0;

  logic        o_stall    [2];
  logic        o_valid    [2];
  logic [31:0] o_bus_a    [2];
  logic [31:0] o_bus_b    [2];
  logic [31:0] o_imm      [2];
  logic [4:0]  o_ra       [2];
  logic [4:0]  o_rb       [2];
  logic [4:0]  o_rd       [2];
  logic        o_mem_read [2];
  logic        o_reg_write[2];
  logic [7:0]  o_ctrl     [2];

  int n_checks = 0;
  int n_fail   = 0;

  exp_t sb[$];
  ex_t  m_ex[2];
  int   m_left[2];

  always #5 clock = ~clock;

  id_ex_stage #(.CTRL_W(8), .LOAD_STALL(1)) u_dut1 (
    .clock(clock), .reset(cur.reset), .id_valid(cur.id_valid), .id_ra(cur.ra),
    .id_rb(cur.rb), .id_rd(cur.rd), .id_uses_rb(cur.uses_rb), .id_bus_a(cur.bus_a),
    .id_bus_b(cur.bus_b), .id_imm(cur.imm), .id_imm_zext(cur.zext),
    .id_mem_read(cur.mem_read), .id_reg_write(cur.reg_write), .id_ctrl(cur.ctrl),
    .flush(cur.flush), .wb_reg_write(cur.wb_we), .wb_rw(cur.wb_rw), .wb_busw(cur.wb_busw),
    .stall_if_id(o_stall[0]), .ex_valid(o_valid[0]), .ex_bus_a(o_bus_a[0]),
    .ex_bus_b(o_bus_b[0]), .ex_imm(o_imm[0]), .ex_ra(o_ra[0]), .ex_rb(o_rb[0]),
    .ex_rd(o_rd[0]), .ex_mem_read(o_mem_read[0]), .ex_reg_write(o_reg_write[0]),
    .ex_ctrl(o_ctrl[0])
  );

  id_ex_stage #(.CTRL_W(8), .LOAD_STALL(3)) u_dut3 (
    .clock(clock), .reset(cur.reset), .id_valid(cur.id_valid), .id_ra(cur.ra),
    .id_rb(cur.rb), .id_rd(cur.rd), .id_uses_rb(cur.uses_rb), .id_bus_a(cur.bus_a),
    .id_bus_b(cur.bus_b), .id_imm(cur.imm), .id_imm_zext(cur.zext),
    .id_mem_read(cur.mem_read), .id_reg_write(cur.reg_write), .id_ctrl(cur.ctrl),
    .flush(cur.flush), .wb_reg_write(cur.wb_we), .wb_rw(cur.wb_rw), .wb_busw(cur.wb_busw),
    .stall_if_id(o_stall[1]), .ex_valid(o_valid[1]), .ex_bus_a(o_bus_a[1]),
    .ex_bus_b(o_bus_b[1]), .ex_imm(o_imm[1]), .ex_ra(o_ra[1]), .ex_rb(o_rb[1]),
    .ex_rd(o_rd[1]), .ex_mem_read(o_mem_read[1]), .ex_reg_write(o_reg_write[1]),
    .ex_ctrl(o_ctrl[1])
  );

  function automatic ex_t get_out(int i);
    ex_t r;
    r.valid     = o_valid[i];
    r.bus_a     = o_bus_a[i];
    r.bus_b     = o_bus_b[i];
    r.imm       = o_imm[i];
    r.ra        = o_ra[i];
    r.rb        = o_rb[i];
    r.rd        = o_rd[i];
    r.mem_read  = o_mem_read[i];
    r.reg_write = o_reg_write[i];
    r.ctrl      = o_ctrl[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_hazard(ex_t e, stim_t s);
    if (!s.id_valid || !e.valid || !e.mem_read || e.rd == 5'd0) return 1'b0;
    return (e.rd == s.ra) || (s.uses_rb && e.rd == s.rb);
  endfunction

  function automatic ex_t capture(stim_t s);
    ex_t r;
    r.valid = 1'b1;
    r.bus_a = s.bus_a;
    r.bus_b = s.bus_b;
`ifdef WB_BYPASS_EN
    if (s.wb_we && s.wb_rw != 5'd0 && s.wb_rw == s.ra) r.bus_a = s.wb_busw;
    if (s.wb_we && s.wb_rw != 5'd0 && s.wb_rw == s.rb) r.bus_b = s.wb_busw;
`endif
    r.imm       = s.zext ? {16'h0000, s.imm} : 32'(signed'(s.imm));
    r.ra        = s.ra;
    r.rb        = s.rb;
    r.rd        = s.rd;
    r.mem_read  = s.mem_read;
    r.reg_write = s.reg_write;
    r.ctrl      = s.ctrl;
    return r;
  endfunction

  task automatic model(input stim_t s, output exp_t e);
    logic st[2];
    for (int i = 0; i < 2; i++) begin
      int   ls;
      ex_t  nx;
      ls    = (i == 0) ? 1 : 3;
      st[i] = 1'b0;
      nx    = '0;
      if (s.reset || s.flush) begin
        m_left[i] = 0;
      end else if (m_left[i] > 0) begin
        st[i] = 1'b1;
        m_left[i]--;
      end else if (is_hazard(m_ex[i], s)) begin
        st[i] = 1'b1;
        m_left[i] = ls - 1;
      end else if (s.id_valid) begin
        nx = capture(s);
      end
      m_ex[i] = nx;
    end
    e.stall0 = st[0];
    e.stall1 = st[1];
    e.e0     = m_ex[0];
    e.e1     = m_ex[1];
  endtask

  // ---------------- stimulus ----------------
  exp_t last_e;

  task automatic step(input stim_t s);
    exp_t e;
    @(negedge clock);
    #1;
    cur = s;
    model(s, e);
    last_e = e;
    sb.push_back(e);
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(3))
      0:       return 5'd0;
      1:       return 5'd3;
      2:       return 5'd5;
      default: return 5'd7;
    endcase
  endfunction

  function automatic stim_t mk(logic v, logic [4:0] ra, logic [4:0] rb, logic [4:0] rd,
                               logic urb, logic ld);
    stim_t s;
    s          = '0;
    s.id_valid = v;
    s.ra       = ra;
    s.rb       = rb;
    s.rd       = rd;
    s.uses_rb  = urb;
    s.mem_read = ld;
    s.reg_write = 1'b1;
    s.bus_a    = {27'h0, ra} + 32'h100;
    s.bus_b    = {27'h0, rb} + 32'h200;
    s.imm      = 16'h1234;
    s.ctrl     = 8'hA5;
    return s;
  endfunction

  // ---------------- monitor ----------------
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clock);
      #3;
      if (sb.size() > 0) begin
        mon_e = sb[0];
        chk("stall_ls1", 128'(o_stall[0]), 128'(mon_e.stall0));
        chk("stall_ls3", 128'(o_stall[1]), 128'(mon_e.stall1));
        @(posedge clock);
        #1;
        chk("ex_ls1", 128'(get_out(0)), 128'(mon_e.e0));
        chk("ex_ls3", 128'(get_out(1)), 128'(mon_e.e1));
        void'(sb.pop_front());
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    stim_t s;
    stim_t prev;
    m_ex[0] = '0;  m_ex[1] = '0;
    m_left[0] = 0; m_left[1] = 0;

    // Reset for two cycles with a valid instruction on the ID inputs.
    s = mk(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0);
    s.reset = 1'b1;
    repeat (2) begin
      step(s);
      @(posedge clock); #2;
      chk("reset_ex_ls1", 128'(get_out(0)), 128'(0));
      chk("reset_ex_ls3", 128'(get_out(1)), 128'(0));
      chk("reset_stall", 128'({o_stall[0], o_stall[1]}), 128'(0));
    end
    s.reset = 1'b0;
    step(s);
    @(posedge clock); #2;
    chk("post_reset_valid", 128'(o_valid[0]), 128'(1));
    chk("post_reset_rd", 128'(o_rd[1]), 128'(4));

    // Immediate extension.
    s = mk(1'b1, 5'd1, 5'd2, 5'd4, 1'b0, 1'b0);
    s.imm = 16'h8001;
    step(s);
    @(posedge clock); #2;
    chk("imm_sext", 128'(o_imm[0]), 128'(32'hFFFF8001));
    s.zext = 1'b1;
    step(s);
    @(posedge clock); #2;
    chk("imm_zext", 128'(o_imm[1]), 128'(32'h00008001));

    // Load-use on ra, then held dependent instruction until it issues.
    step(mk(1'b1, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1));
    s = mk(1'b1, 5'd5, 5'd2, 5'd6, 1'b0, 1'b0);
    step(s);
    @(posedge clock); #2;
    chk("stall_bubble", 128'({o_valid[0], o_valid[1]}), 128'(0));
    repeat (3) step(s);
    // Load to r0 never stalls.
    step(mk(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1));
    step(mk(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0));
    // uses_rb gating on rb=7.
    step(mk(1'b1, 5'd1, 5'd2, 5'd7, 1'b0, 1'b1));
    step(mk(1'b1, 5'd1, 5'd7, 5'd6, 1'b0, 1'b0));
    step(mk(1'b1, 5'd1, 5'd2, 5'd7, 1'b0, 1'b1));
    s = mk(1'b1, 5'd1, 5'd7, 5'd6, 1'b1, 1'b0);
    repeat (4) step(s);
    // Flush together with a hazard, then flush during STALL.
    step(mk(1'b1, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1));
    s = mk(1'b1, 5'd5, 5'd2, 5'd6, 1'b0, 1'b0);
    s.flush = 1'b1;
    step(s);
    step(mk(1'b1, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1));
    s.flush = 1'b0;
    step(s);
    s.flush = 1'b1;
    step(s);
    s.flush = 1'b0;
    step(s);

    // Write-back bypass.
    s = mk(1'b1, 5'd3, 5'd2, 5'd6, 1'b0, 1'b0);
    s.bus_a = 32'h3;
    s.wb_we = 1'b1; s.wb_rw = 5'd3; s.wb_busw = 32'hDEADBEEF;
    step(s);
    @(posedge clock); #2;
`ifdef WB_BYPASS_EN
    chk("bypass_a", 128'(o_bus_a[0]), 128'(32'hDEADBEEF));
`else
    chk("no_bypass_a", 128'(o_bus_a[0]), 128'(32'h3));
`endif
    s.ra = 5'd0; s.wb_rw = 5'd0;
    step(s);
    @(posedge clock); #2;
    chk("bypass_r0", 128'(o_bus_a[1]), 128'(32'h3));

    // Randomised traffic; ID holds its instruction while stalled.
    prev = s;
    for (int n = 0; n < 2000; n++) begin
      if ((last_e.stall0 || last_e.stall1) && $urandom_range(3) != 0) begin
        s = prev;
      end else begin
        s = mk(($urandom_range(3) != 0), pick_reg(), pick_reg(), pick_reg(),
               1'($urandom_range(1)), 1'($urandom_range(1)));
        s.bus_a     = $urandom;
        s.bus_b     = $urandom;
        s.imm       = 16'($urandom);
        s.zext      = 1'($urandom_range(1));
        s.reg_write = 1'($urandom_range(1));
        s.ctrl      = 8'($urandom);
      end
      s.reset   = ($urandom_range(49) == 0);
      s.flush   = ($urandom_range(7) == 0);
      s.wb_we   = 1'($urandom_range(1));
      s.wb_rw   = pick_reg();
      s.wb_busw = $urandom;
      step(s);
      prev = s;
    end

    step(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0));
    repeat (3) @(posedge clock);
    #2;
    chk("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the MIPS-DLX core. Sits directly downstream of the register bank and decode logic.
- Captures bus_a/bus_b, the extended immediate, register indices and the control bundle on each clock edge.
- Detects load-use hazards against the instruction currently in EX, stalls IF/ID and inserts bubbles into EX.
- Squashes the EX slot on a taken-branch flush.

Parameters:
- CTRL_W, 8, width of the opaque EX/MEM/WB control bundle passed through.
- LOAD_STALL, 1, bubbles inserted per load-use hazard (legal 1..3).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID slot holds a valid instruction.
- id_ra  in  5  source register A index (as driven to register bank ra).
- id_rb  in  5  source register B index.
- id_rd  in  5  destination register index.
- id_uses_rb  in  1  instruction actually reads rb.
- id_bus_a  in  32  register bank bus_a.
- id_bus_b  in  32  register bank bus_b.
- id_imm  in  16  raw immediate field.
- id_imm_zext  in  1  1 = zero-extend immediate, 0 = sign-extend.
- id_mem_read  in  1  instruction is a load.
- id_reg_write  in  1  instruction writes rd.
- id_ctrl  in  CTRL_W  remaining control bundle.
- flush  in  1  taken branch resolved in EX; squash.
- wb_reg_write  in  1  write-back enable (same signal as register bank reg_write).
- wb_rw  in  5  write-back destination.
- wb_busw  in  32  write-back data.
- stall_if_id  out  1  hold PC and IF/ID this cycle (combinational).
- ex_valid  out  1  EX slot valid.
- ex_bus_a, ex_bus_b  out  32  captured operands.
- ex_imm  out  32  extended immediate.
- ex_ra, ex_rb, ex_rd  out  5  captured indices.
- ex_mem_read, ex_reg_write  out  1  captured control.
- ex_ctrl  out  CTRL_W  captured control bundle.

Behaviour:
- Reset (synchronous, active-high, on posedge clock): all ex_* outputs are 0, FSM is RUN, stall counter is 0, stall_if_id is 0. Reset overrides flush and hazard.
- Latency: 1 cycle. ID inputs present before edge N appear on ex_* after edge N.
- Immediate: ex_imm = {16{id_imm[15] & ~id_imm_zext}, id_imm}.
- Bubble: all ex_* outputs are loaded with 0, including data fields, so r0 is the destination.
- hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == id_ra) | (id_uses_rb & ex_rd == id_rb)).
- FSM RUN:
  - If flush: bubble; stall_if_id = 0; stay in RUN.
  - Else if hazard: stall_if_id = 1; bubble; cnt <= LOAD_STALL-1; next state is STALL if LOAD_STALL > 1, else RUN.
  - Else if id_valid: capture ID fields; stall_if_id = 0.
  - Else: bubble.
- FSM STALL:
  - stall_if_id = 1; bubble; cnt <= cnt-1; go to RUN when cnt == 1.
  - flush in STALL: bubble, stall_if_id = 0, state <= RUN, cnt <= 0.
- Total stalled cycles per hazard is exactly LOAD_STALL. In STALL, the ID instruction is not re-checked against the bubble in EX; it issues on the first RUN cycle after the stall.
- Back-to-back loads: a load issued after a stall can itself trigger a new hazard on the next instruction; handled normally.
- Register 0 is never a hazard source.
- Simultaneous flush and hazard: flush wins, no stall.
- Reset mid-stall: returns to RUN immediately, cnt = 0, stall_if_id = 0 the cycle after reset is released.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: on capture, if wb_reg_write & (wb_rw != 0) & (wb_rw == id_ra), ex_bus_a <= wb_busw instead of id_bus_a. Same rule for rb and ex_bus_b. This makes operand capture independent of register bank write-edge timing.
- Undefined: id_bus_a/id_bus_b are captured unchanged; the wb_* ports are present but ignored. This relies on the register bank writing on negedge.

Test Plan:
- Reset: assert reset 2 cycles with id_valid=1 -> all ex_* = 0, stall_if_id=0; first edge after release captures the ID fields.
- Sign/zero extension: id_imm=16'h8001 with zext=0 -> ex_imm=32'hFFFF8001; with zext=1 -> 32'h00008001.
- Load-use: EX holds a load with ex_rd=5, ID has ra=5 -> stall_if_id=1 for LOAD_STALL cycles (check 1 and 3), ex_valid=0 during the stall, then the ID instruction is captured. With ex_rd=0 -> no stall.
- uses_rb gating: ex_rd=7 load, id_rb=7 -> stall only when id_uses_rb=1.
- Flush: flush during RUN-with-hazard and during STALL (LOAD_STALL=3, cnt=2) -> next ex_valid=0, stall_if_id=0, FSM in RUN.
- Bypass (WB_BYPASS_EN defined): wb_reg_write=1, wb_rw=3, wb_busw=32'hDEADBEEF, id_ra=3, id_bus_a=32'h3 -> ex_bus_a=32'hDEADBEEF. With the macro undefined -> ex_bus_a=32'h3. With wb_rw=0 -> no bypass.
